// File: rtl/fir_pkg.sv
// Shared register map, ap_ctrl bit positions and state encodings for the FIR configuration master.
package fir_pkg;

  localparam int unsigned AP_CTRL_OFS  = 32'h00;
  localparam int unsigned DATA_LEN_OFS = 32'h10;
  localparam int unsigned TAP_BASE_OFS = 32'h20;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LEN,
    S_WR_TAP,
    S_RD_TAP,
    S_WR_START,
    S_POLL,
    S_FIN
  } cfg_state_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_WRITE,
    X_RADDR,
    X_RDATA
  } xact_state_e;

  function automatic int unsigned tap_ofs(input int unsigned k);
    return TAP_BASE_OFS + 4 * k;
  endfunction

endpackage

// File: rtl/axil_master_xact.sv
// Single-outstanding AXI-Lite write/read handshake engine; one request per transaction.
module axil_master_xact
  import fir_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              cmp,
  output logic [DATA_W-1:0] rd_data,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  output logic [DATA_W-1:0] wdata,
  input  logic              wready,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic              rready
);

  xact_state_e       xstate_q, xstate_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Channel sequencing: AW and W retire independently, the write completes once both have.
  always_comb begin
    xstate_d  = xstate_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    cmp       = 1'b0;
    rd_data   = rdata;
    case (xstate_q)
      X_IDLE: begin
        if (req) begin
          if (req_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            xstate_d  = X_WRITE;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
            xstate_d  = X_RADDR;
          end
        end
      end
      X_WRITE: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          cmp      = 1'b1;
          xstate_d = X_IDLE;
        end
      end
      X_RADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          xstate_d  = X_RDATA;
        end
      end
      X_RDATA: begin
        if (rvalid) begin
          rready_d = 1'b0;
          cmp      = 1'b1;
          xstate_d = X_IDLE;
        end
      end
      default: xstate_d = X_IDLE;
    endcase
  end

  // Channel registers; reset drops every valid/ready even mid-transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      xstate_q  <= X_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      xstate_q  <= xstate_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign awvalid = awvalid_q;
  assign awaddr  = awaddr_q;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign rready  = rready_q;

endmodule

// File: rtl/fir_cfg_master.sv
// Sequences FIR configuration: length, taps, tap readback check, ap_start and ap_done polling.
module fir_cfg_master
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [31:0]            data_length,
  output logic [3:0]             coef_idx,
  input  logic [31:0]            coef_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [3:0]             err_idx,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);

  localparam logic [3:0] LAST_K = 4'(Tape_Num - 1);

  cfg_state_e             state_q, state_d;
  logic [3:0]             k_q, k_d;
  logic                   pend_q, pend_d;
  logic [31:0]            len_q, len_d;
  logic                   err_q, err_d;
  logic [3:0]             err_idx_q, err_idx_d;

  logic                   xreq;
  logic                   xreq_wr;
  logic [pADDR_WIDTH-1:0] xaddr;
  logic [pDATA_WIDTH-1:0] xwdata;
  logic                   xcmp;
  logic [pDATA_WIDTH-1:0] xrdata;

  axil_master_xact #(
    .ADDR_W (pADDR_WIDTH),
    .DATA_W (pDATA_WIDTH)
  ) u_xact (
    .clk       (axis_clk),
    .rst       (axis_rst),
    .req       (xreq),
    .req_wr    (xreq_wr),
    .req_addr  (xaddr),
    .req_wdata (xwdata),
    .cmp       (xcmp),
    .rd_data   (xrdata),
    .awvalid   (awvalid),
    .awaddr    (awaddr),
    .awready   (awready),
    .wvalid    (wvalid),
    .wdata     (wdata),
    .wready    (wready),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .arready   (arready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rready    (rready)
  );

  // Next-state logic; each transaction state issues one request then waits for its completion.
  // pend_q guarantees the next request lands at least one cycle after the previous completion.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pend_d    = pend_q;
    len_d     = len_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    xreq      = 1'b0;
    xreq_wr   = 1'b0;
    xaddr     = '0;
    xwdata    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = data_length;
          err_d     = 1'b0;
          err_idx_d = '0;
          state_d   = S_WR_LEN;
        end
      end
      S_WR_LEN: begin
        xreq    = !pend_q;
        xreq_wr = 1'b1;
        xaddr   = pADDR_WIDTH'(DATA_LEN_OFS);
        xwdata  = pDATA_WIDTH'(len_q);
        if (xcmp) state_d = S_WR_TAP;
      end
      S_WR_TAP: begin
        xreq    = !pend_q;
        xreq_wr = 1'b1;
        xaddr   = pADDR_WIDTH'(tap_ofs(32'(k_q)));
        xwdata  = pDATA_WIDTH'(coef_data);
        if (xcmp) begin
          if (k_q == LAST_K) begin
            k_d     = '0;
            state_d = S_RD_TAP;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      S_RD_TAP: begin
        xreq  = !pend_q;
        xaddr = pADDR_WIDTH'(tap_ofs(32'(k_q)));
        if (xcmp) begin
          if (32'(xrdata) != coef_data) begin
            err_d     = 1'b1;
            err_idx_d = k_q;
            k_d       = '0;
            state_d   = S_FIN;
          end else if (k_q == LAST_K) begin
            k_d     = '0;
            state_d = S_WR_START;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      S_WR_START: begin
        xreq    = !pend_q;
        xreq_wr = 1'b1;
        xaddr   = pADDR_WIDTH'(AP_CTRL_OFS);
        xwdata  = pDATA_WIDTH'(32'd1 << AP_START_BIT);
        if (xcmp) state_d = S_POLL;
      end
      S_POLL: begin
        xreq  = !pend_q;
        xaddr = pADDR_WIDTH'(AP_CTRL_OFS);
        if (xcmp && xrdata[AP_DONE_BIT]) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (xreq) pend_d = 1'b1;
    if (xcmp) pend_d = 1'b0;
  end

  // Sequencer state registers.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      pend_q    <= 1'b0;
      len_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pend_q    <= pend_d;
      len_q     <= len_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign err      = err_q;
  assign err_idx  = err_idx_q;
  assign coef_idx = (state_q == S_WR_TAP || state_q == S_RD_TAP) ? k_q : '0;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master with an AXI-Lite slave model and a transaction-level expectation model.
module tb_fir_cfg_master;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int NT    = 11;
  localparam int POLLS = 5;

  logic          axis_clk = 1'b0;
  logic          axis_rst;
  logic          start;
  logic [31:0]   data_length;
  logic [3:0]    coef_idx;
  logic [31:0]   coef_data;
  logic          busy, done, err;
  logic [3:0]    err_idx;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;

  fir_cfg_master #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .Tape_Num    (NT)
  ) dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .start       (start),
    .data_length (data_length),
    .coef_idx    (coef_idx),
    .coef_data   (coef_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_idx     (err_idx),
    .awvalid     (awvalid),
    .awaddr      (awaddr),
    .awready     (awready),
    .wvalid      (wvalid),
    .wdata       (wdata),
    .wready      (wready),
    .arvalid     (arvalid),
    .araddr      (araddr),
    .arready     (arready),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .rready      (rready)
  );

  always #5 axis_clk = ~axis_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Host coefficient table
  int taps [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  always_comb begin
    coef_data = '0;
    if (int'(coef_idx) < NT) coef_data = 32'(taps[int'(coef_idx)]);
  end

  // Expected transaction model
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];

  function automatic void build_expect(input logic [31:0] len, input int bad);
    wr_t e;
    exp_wr.delete();
    exp_rd.delete();
    e.addr = 32'h10; e.data = len;
    exp_wr.push_back(e);
    for (int k = 0; k < NT; k++) begin
      e.addr = 32'(32'h20 + 4 * k);
      e.data = 32'(taps[k]);
      exp_wr.push_back(e);
    end
    for (int k = 0; k < NT; k++) begin
      exp_rd.push_back(32'(32'h20 + 4 * k));
      if (k == bad) break;
    end
    if (bad < 0) begin
      e.addr = 32'h0; e.data = 32'h1;
      exp_wr.push_back(e);
      for (int p = 0; p < POLLS; p++) exp_rd.push_back(32'h0);
    end
  endfunction

  // AXI-Lite slave model with configurable ready latency
  int          aw_dly = 0, w_dly = 0, bad_tap = -1;
  int          aw_wait, w_wait, poll_cnt;
  logic        s_aw_got, s_w_got, rvalid_r;
  logic [31:0] s_aa, s_wd, rdata_r;
  logic [31:0] mem [64];
  logic        hs_aw, hs_w, hs_ar, s_commit;
  logic [31:0] s_cur_a, s_cur_d;

  assign awready  = awvalid && (aw_wait >= aw_dly);
  assign wready   = wvalid && (w_wait >= w_dly);
  assign arready  = 1'b1;
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign hs_aw    = awvalid && awready;
  assign hs_w     = wvalid && wready;
  assign hs_ar    = arvalid && arready;
  assign s_commit = (s_aw_got || hs_aw) && (s_w_got || hs_w);
  assign s_cur_a  = hs_aw ? 32'(awaddr) : s_aa;
  assign s_cur_d  = hs_w ? 32'(wdata) : s_wd;

  always @(posedge axis_clk) begin
    if (axis_rst) begin
      aw_wait  <= 0;
      w_wait   <= 0;
      poll_cnt <= 0;
      s_aw_got <= 1'b0;
      s_w_got  <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (hs_aw) s_aa <= 32'(awaddr);
      if (hs_w)  s_wd <= 32'(wdata);
      if (s_commit) begin
        mem[s_cur_a[7:2]] <= s_cur_d;
        if (s_cur_a == 32'h0) poll_cnt <= 0;
        s_aw_got <= 1'b0;
        s_w_got  <= 1'b0;
      end else begin
        if (hs_aw) s_aw_got <= 1'b1;
        if (hs_w)  s_w_got  <= 1'b1;
      end
      if (rvalid_r && rready) rvalid_r <= 1'b0;
      if (hs_ar) begin
        rvalid_r <= 1'b1;
        if (araddr == '0) begin
          poll_cnt <= poll_cnt + 1;
          rdata_r  <= (poll_cnt + 1 >= POLLS) ? 32'h2 : 32'h0;
        end else if (bad_tap >= 0 && 32'(araddr) == 32'(32'h20 + 4 * bad_tap)) begin
          rdata_r <= 32'd99;
        end else begin
          rdata_r <= mem[araddr[7:2]];
        end
      end
    end
  end

  // Compare process: protocol rules every cycle, transactions against the expectation queues
  logic          pa_pend, pw_pend, par_pend, ar_hs_prev, done_prev;
  logic [AW-1:0] pa, par;
  logic [DW-1:0] pw;
  logic          m_aw_seen, m_w_seen, m_commit;
  logic [31:0]   m_aa, m_wd, m_ra, m_cur_a, m_cur_d;
  int            done_cnt = 0, wr_obs = 0, rd_obs = 0;

  assign m_commit = (m_aw_seen || hs_aw) && (m_w_seen || hs_w);
  assign m_cur_a  = hs_aw ? 32'(awaddr) : m_aa;
  assign m_cur_d  = hs_w ? 32'(wdata) : m_wd;

  always @(negedge axis_clk) begin
    if (axis_rst) begin
      pa_pend    <= 1'b0;
      pw_pend    <= 1'b0;
      par_pend   <= 1'b0;
      ar_hs_prev <= 1'b0;
      done_prev  <= 1'b0;
      m_aw_seen  <= 1'b0;
      m_w_seen   <= 1'b0;
    end else begin
      if (pa_pend) begin
        check("aw_hold_valid", 32'(awvalid), 32'd1);
        check("aw_hold_addr", 32'(awaddr), 32'(pa));
      end
      if (pw_pend) begin
        check("w_hold_valid", 32'(wvalid), 32'd1);
        check("w_hold_data", 32'(wdata), 32'(pw));
      end
      if (par_pend) begin
        check("ar_hold_valid", 32'(arvalid), 32'd1);
        check("ar_hold_addr", 32'(araddr), 32'(par));
      end
      if (ar_hs_prev) check("rready_after_ar", 32'(rready), 32'd1);
      if (rready) check("rready_not_with_ar", 32'(arvalid), 32'd0);
      if (awvalid || wvalid) check("single_outstanding", 32'(arvalid || rready), 32'd0);
      if (!busy) check("idle_quiet", 32'({coef_idx, awvalid, wvalid, arvalid, rready, done}), 32'd0);
      pa_pend    <= awvalid && !awready;
      pw_pend    <= wvalid && !wready;
      par_pend   <= arvalid && !arready;
      pa         <= awaddr;
      pw         <= wdata;
      par        <= araddr;
      ar_hs_prev <= hs_ar;
      if (hs_aw) m_aa <= 32'(awaddr);
      if (hs_w)  m_wd <= 32'(wdata);
      if (m_commit) begin
        m_aw_seen <= 1'b0;
        m_w_seen  <= 1'b0;
        wr_obs    <= wr_obs + 1;
        if (exp_wr.size() == 0) begin
          check("wr_extra", m_cur_a, 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", m_cur_a, exp_wr[0].addr);
          check("wr_data", m_cur_d, exp_wr[0].data);
          void'(exp_wr.pop_front());
        end
        if (m_cur_a >= 32'h20) check("wr_coef_idx", 32'(coef_idx), (m_cur_a - 32'h20) >> 2);
      end else begin
        if (hs_aw) m_aw_seen <= 1'b1;
        if (hs_w)  m_w_seen  <= 1'b1;
      end
      if (hs_ar) m_ra <= 32'(araddr);
      if (rvalid && rready) begin
        rd_obs <= rd_obs + 1;
        if (exp_rd.size() == 0) begin
          check("rd_extra", m_ra, 32'hFFFF_FFFF);
        end else begin
          check("rd_addr", m_ra, exp_rd[0]);
          void'(exp_rd.pop_front());
        end
        if (m_ra >= 32'h20) check("rd_coef_idx", 32'(coef_idx), (m_ra - 32'h20) >> 2);
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        check("done_one_cycle", 32'(done_prev), 32'd0);
      end
      done_prev <= done;
    end
  end

  // Driver tasks
  int exp_done = 0;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, 32'({awvalid, wvalid, arvalid, rready}), 32'd0);
    check({tag, "_addr"}, 32'({awaddr, araddr}), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_status"}, 32'({busy, done, err}), 32'd0);
    check({tag, "_idx"}, 32'({err_idx, coef_idx}), 32'd0);
  endtask

  task automatic launch(input logic [31:0] len, input int bad);
    bad_tap = bad;
    build_expect(len, bad);
    @(negedge axis_clk);
    start       = 1'b1;
    data_length = len;
    @(negedge axis_clk);
    start       = 1'b0;
    data_length = 32'hDEAD_BEEF;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
  endtask

  // mode 0: plain wait; 1: extra start during WR_TAP; 2: reset during RD_TAP with arvalid
  task automatic wait_done(input int mode);
    bit got = 0;
    bit injected = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge axis_clk);
      start = 1'b0;
      if (mode == 2 && busy && arvalid && coef_idx == 4'd2) begin
        axis_rst = 1'b1;
        @(negedge axis_clk);
        check_reset_outputs("mid_reset");
        #1 axis_rst = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        got = 1;
        break;
      end
      if (done) begin
        got = 1;
        break;
      end
      if (mode == 1 && !injected && busy && awvalid && awaddr == 12'h02C) begin
        start    = 1'b1;
        injected = 1;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic post_checks(input int bad);
    repeat (2) @(negedge axis_clk);
    check("wr_left", 32'(exp_wr.size()), 32'd0);
    check("rd_left", 32'(exp_rd.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(exp_done));
    check("err_flag", 32'(err), (bad >= 0) ? 32'd1 : 32'd0);
    if (bad >= 0) check("err_idx", 32'(err_idx), 32'(bad));
    check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int w0, r0;
    axis_rst    = 1'b1;
    start       = 1'b0;
    data_length = '0;
    repeat (3) @(negedge axis_clk);
    check_reset_outputs("reset");
    #1 axis_rst = 1'b0;

    // Model pins
    build_expect(32'd600, -1);
    check("model_wr_n", 32'(exp_wr.size()), 32'd13);
    check("model_rd_n", 32'(exp_rd.size()), 32'd16);
    check("model_tap3", exp_wr[4].data, 32'd23);
    check("model_tap1", exp_wr[2].data, 32'hFFFF_FFF6);
    check("model_start_addr", exp_wr[12].addr, 32'h0);
    build_expect(32'd600, 4);
    check("model_bad_rd_n", 32'(exp_rd.size()), 32'd5);

    // Nominal
    w0 = wr_obs; r0 = rd_obs;
    launch(32'd600, -1);
    wait_done(0);
    exp_done++;
    post_checks(-1);
    check("nominal_writes", 32'(wr_obs - w0), 32'd13);
    check("nominal_reads", 32'(rd_obs - r0), 32'd16);

    // Backpressure
    aw_dly = 3; w_dly = 1;
    launch(32'd600, -1);
    wait_done(0);
    exp_done++;
    post_checks(-1);
    aw_dly = 0; w_dly = 0;

    // Readback mismatch on tap 4
    w0 = wr_obs;
    launch(32'd600, 4);
    wait_done(0);
    exp_done++;
    post_checks(4);
    check("mismatch_writes", 32'(wr_obs - w0), 32'd12);

    // Start while busy
    launch(32'd100, -1);
    wait_done(1);
    exp_done++;
    post_checks(-1);

    // Mid-sequence reset then a full run
    launch(32'd600, -1);
    wait_done(2);
    launch(32'd600, -1);
    wait_done(0);
    exp_done++;
    post_checks(-1);

    // Back-to-back: failing run, restart in the cycle after done
    launch(32'd250, 7);
    wait_done(0);
    exp_done++;
    check("b2b_err_first", 32'(err), 32'd1);
    check("b2b_err_idx_first", 32'(err_idx), 32'd7);
    launch(32'd250, -1);
    wait_done(0);
    exp_done++;
    post_checks(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
